// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine owning the HI/LO pair: one bit per cycle via shift-add
// multiply or restoring divide, with sign fixup and a start/busy/done handshake.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             abort,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PREP  = 2'd1;
    localparam logic [1:0] S_CALC  = 2'd2;
    localparam logic [1:0] S_FIXUP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_out_q, dbz_out_d;

    logic               is_div, a_sgn, b_sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, mul_upper;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Datapath helpers; the unsigned magnitude of the most negative value still fits in WIDTH bits.
    always_comb begin
        is_div    = op_q[1];
        a_sgn     = ~op_q[0] & a_q[WIDTH-1];
        b_sgn     = ~op_q[0] & b_q[WIDTH-1];
        a_mag     = a_sgn ? -a_q : a_q;
        b_mag     = b_sgn ? -b_q : b_q;
        mul_sum   = {1'b0, acc_q} + {1'b0, opnd_q};
        mul_upper = work_q[0] ? mul_sum : {1'b0, acc_q};
        rem_sh    = {acc_q, work_q[WIDTH-1]};
        div_ge    = rem_sh >= {1'b0, opnd_q};
        rem_sub   = rem_sh[WIDTH-1:0] - opnd_q;
        prod      = {acc_q, work_q};
        prod_fix  = neg_quo_q ? -prod : prod;
        quo_fix   = neg_quo_q ? -work_q : work_q;
        rem_fix   = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
                if (start) begin
                    state_d = S_PREP;
                    op_d    = op;
                    a_d     = src_a;
                    b_d     = src_b;
                end
            end
            S_PREP: begin
                opnd_d    = is_div ? b_mag : a_mag;
                work_d    = is_div ? a_mag : b_mag;
                acc_d     = '0;
                cnt_d     = CW'(WIDTH - 1);
                neg_quo_d = a_sgn ^ b_sgn;
                neg_rem_d = a_sgn;
                dbz_d     = is_div && (b_q == '0);
                state_d   = S_CALC;
            end
            S_CALC: begin
                if (is_div) begin
                    acc_d  = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d  = mul_upper[WIDTH:1];
                    work_d = {mul_upper[0], work_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = S_FIXUP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                if (dbz_q) begin
                    hi_d      = a_q;
                    lo_d      = '1;
                    dbz_out_d = 1'b1;
                end else if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything in flight, including the commit in FIXUP.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            done_d    = 1'b0;
            dbz_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, divide by zero,
// abort, start-while-busy, direct HI/LO writes and reset mid-operation.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk = 1'b0;
    logic         rst, start, abort, hiWr, loWr;
    logic [1:0]   op;
    logic [W-1:0] srcA, srcB, wrData;
    logic         busy, done, divByZero;
    logic [W-1:0] hi, lo;

    int checkCount = 0;
    int passCount  = 0;
    int lat;
    int seen;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(srcA), .src_b(srcB),
        .abort(abort), .hi_wr(hiWr), .lo_wr(loWr), .wr_data(wrData),
        .busy(busy), .done(done), .div_by_zero(divByZero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Presents an op with start for exactly one rising edge (the start edge).
    task automatic applyStimulus(input logic [1:0] opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn);
        op    = opIn;
        srcA  = aIn;
        srcB  = bIn;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int already, output int latency);
        latency = already;
        while (!done && latency < 200) begin
            tick();
            latency++;
        end
    endtask

    task automatic watchNoDone(input int n, output int count);
        count = 0;
        repeat (n) begin
            tick();
            if (done) count++;
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] opIn, input logic [W-1:0] aIn,
                         input logic [W-1:0] bIn, input logic [W-1:0] expHi,
                         input logic [W-1:0] expLo, input logic expDbz);
        int l;
        applyStimulus(opIn, aIn, bIn);
        waitDone(0, l);
        checkOutput({tag, "_latency"}, 64'(l), 64'd34);
        checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
        checkOutput({tag, "_dbz"}, 64'(divByZero), 64'(expDbz));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; hiWr = 1'b0; loWr = 1'b0;
        op = '0; srcA = '0; srcB = '0; wrData = '0;
        tick();
        tick();
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        tick();

        runOp("mult_7x-3", OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        tick();
        checkOutput("done_pulse", 64'(done), 64'd0);
        checkOutput("hi_stable", 64'(hi), 64'hFFFFFFFF);

        runOp("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        runOp("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        runOp("div_-7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        runOp("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        runOp("divu_by0", OP_DIVU, 32'h0000000A, 32'd0, 32'h0000000A, 32'hFFFFFFFF, 1'b1);
        runOp("divu_100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // Both direct writes together, then a write landing in the same cycle as start.
        hiWr = 1'b1; loWr = 1'b1; wrData = 32'h0000A5A5;
        tick();
        hiWr = 1'b0; loWr = 1'b0;
        checkOutput("both_wr_hi", 64'(hi), 64'h0000A5A5);
        checkOutput("both_wr_lo", 64'(lo), 64'h0000A5A5);
        hiWr = 1'b1; wrData = 32'h55;
        applyStimulus(OP_MULTU, 32'd2, 32'd3);
        hiWr = 1'b0;
        checkOutput("wr_with_start_hi", 64'(hi), 64'h55);
        waitDone(0, lat);
        checkOutput("wr_with_start_lat", 64'(lat), 64'd34);
        checkOutput("wr_with_start_final_hi", 64'(hi), 64'd0);
        checkOutput("wr_with_start_final_lo", 64'(lo), 64'd6);

        // Preload, then abort a divide partway; a write while busy must also be dropped.
        hiWr = 1'b1; wrData = 32'h11;
        tick();
        hiWr = 1'b0; loWr = 1'b1; wrData = 32'h22;
        tick();
        loWr = 1'b0;
        applyStimulus(OP_DIVU, 32'd100, 32'd3);
        hiWr = 1'b1; wrData = 32'h99;
        tick();
        hiWr = 1'b0;
        repeat (8) tick();
        checkOutput("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy_after", 64'(busy), 64'd0);
        watchNoDone(40, seen);
        checkOutput("abort_no_done", 64'(seen), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'h11);
        checkOutput("abort_lo", 64'(lo), 64'h22);

        // A second start while busy is neither taken nor queued.
        applyStimulus(OP_MULTU, 32'd5, 32'd6);
        tick();
        op = OP_DIVU; srcA = 32'd9; srcB = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(2, lat);
        checkOutput("busy_start_lat", 64'(lat), 64'd34);
        checkOutput("busy_start_hi", 64'(hi), 64'd0);
        checkOutput("busy_start_lo", 64'(lo), 64'h1E);
        watchNoDone(40, seen);
        checkOutput("busy_start_no_queue", 64'(seen), 64'd0);

        // Reset in the middle of an operation clears HI/LO immediately.
        applyStimulus(OP_MULT, 32'd3, 32'd4);
        repeat (14) tick();
        checkOutput("midreset_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_hi", 64'(hi), 64'd0);
        checkOutput("midreset_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        watchNoDone(40, seen);
        checkOutput("midreset_no_done", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
